ir_err_gen: RTL and testbench
=============================

// Module: ir_err_gen
// PURPOSE
//  Producer side of the error/err_vld/line_present interface consumed by the PID controller.
//  Periodically enables IR emitters and sequences 8 A2D conversions (ch0 far-left .. ch7 far-right).
//  Forms a signed weighted line-position error, saturates it to 16 bits, and reports line_present.
//  Sits between the A2D/SPI interface (strt_cnv/cnv_cmplt handshake) and PID.
// PARAMETERS
//  PERIOD_CYC  4096    idle cycles between frames (1..65535)
//  SETTLE_CYC  256     cycles IR_en held high before first conversion (1..65535)
//  LINE_THRES  12'h040 a channel reading strictly greater than this value counts as line seen
// PORTS
//  clk           in   1   clock, all state updates on the rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  go            in   1   run enable; low = synchronous abort to IDLE
//  cnv_cmplt     in   1   1-cycle pulse from A2D interface: res valid
//  res           in   12  unsigned conversion result, valid while cnv_cmplt is high
//  strt_cnv      out  1   1-cycle pulse requesting a conversion on chnnl
//  chnnl         out  3   channel being converted, held stable until cnv_cmplt
//  IR_en         out  1   IR emitter enable
//  error         out  16  signed saturated error, held between frames
//  err_vld       out  1   1-cycle pulse, error/line_present updated this cycle
//  line_present  out  1   any channel > LINE_THRES in the last completed frame
// BEHAVIOUR
//  Reset values: strt_cnv=0, chnnl=0, IR_en=0, error=0, err_vld=0, line_present=0.
//   Internal state also resets: state=IDLE, timer=0, acc=0.
//  States:
//   IDLE   : IR_en=0; timer increments while go=1; timer==PERIOD_CYC-1 -> SETTLE, timer=0.
//   SETTLE : IR_en=1; timer==SETTLE_CYC-1 -> CONV with chnnl=0, acc=0, seen=0.
//   CONV   : strt_cnv=1 for exactly this one cycle -> WAIT.
//   WAIT   : hold chnnl, IR_en=1. On cnv_cmplt: update acc and seen.
//            chnnl==7 -> DONE; otherwise chnnl+1 -> CONV.
//   DONE   : one cycle. IR_en=0. error<=sat16(acc), line_present<=seen, err_vld=1. -> IDLE, timer=0.
//  Weights: ch0..ch7 = -8,-4,-2,-1,+1,+2,+4,+8.
//   acc is 17-bit signed; term = {5'b0,res} shifted left 3/2/1/0 and added or subtracted.
//  Saturation: acc>32767 -> 16'h7FFF; acc<-32768 -> 16'h8000; else acc[15:0].
//  err_vld rises the cycle after the 8th cnv_cmplt.
//   Min frame length = PERIOD_CYC + SETTLE_CYC + 8*(1+A2D latency) + 1 cycles.
//  cnv_cmplt outside WAIT is ignored.
//   cnv_cmplt in the same cycle as strt_cnv is also ignored (the response is only accepted in WAIT).
//  go=0 in any state: next cycle IDLE, IR_en=0, timer=0, acc=0, no err_vld.
//   error and line_present are held.
//  No timeout: WAIT waits indefinitely for cnv_cmplt; go=0 is the only exit.
//  Async reset mid-frame returns all outputs to reset values immediately.
// CONFIGURATION
//  ERR_FILTER_EN defined:
//   error <= (sat16(acc) + prev) >>> 1, computed in 17-bit signed.
//   prev <= sat16(acc) on each DONE; prev resets to 0 and is cleared when go=0.
//   Output latency is unchanged.
//  ERR_FILTER_EN undefined: error <= sat16(acc); prev register is not built.
// TESTING (PERIOD_CYC=16, SETTLE_CYC=4, A2D model answers 3 cycles after strt_cnv)
//  1 Frame timing:
//    all res=12'h100 -> error=0, line_present=1, one err_vld pulse.
//    8 strt_cnv pulses, chnnl sequence 0..7.
//    IR_en high from SETTLE entry through the 8th cnv_cmplt.
//  2 Weights / no saturation:
//    ch7=12'hFFF, others 0 -> error=16'sd32760 (16'h7FF8).
//    ch3=12'h010, others 0 -> error=-16.
//  3 Saturation:
//    ch6=ch7=12'hFFF -> error=16'h7FFF.
//    ch0=ch1=12'hFFF -> error=16'h8000.
//  4 No line:
//    all res=12'h040 (== threshold) -> line_present=0, error=0, err_vld still pulses.
//    Next frame with ch5=12'h041 -> line_present=1.
//  5 Abort:
//    go=0 while in WAIT on ch3 -> IR_en=0 next cycle, no err_vld, prior error held.
//    A late cnv_cmplt arriving in IDLE is ignored.
//    go=1 -> a full new frame starts at ch0.
//  6 ERR_FILTER_EN:
//    frame1 ch4=1000 -> error=500.
//    frame2 ch4=3000 -> error=2000.
//    Without the macro the same frames give 1000, then 3000.

Source files
------------

// File: rtl/ir_err_gen.sv
// ir_err_gen: enables the IR emitters, reads 8 A2D channels and reports a saturated weighted line error.
// Defining ERR_FILTER_EN averages each new error with the previous frame's saturated error.
module ir_err_gen #(
  parameter int unsigned PERIOD_CYC = 4096,
  parameter int unsigned SETTLE_CYC = 256,
  parameter logic [11:0] LINE_THRES = 12'h040
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic        IR_en,
  output logic [15:0] error,
  output logic        err_vld,
  output logic        line_present
);

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, WAIT, DONE} state_e;

  state_e             state_q, state_d;
  logic [15:0]        timer_q, timer_d;
  logic signed [16:0] acc_q, acc_d;
  logic               seen_q, seen_d;
  logic [2:0]         chnnl_q, chnnl_d;
  logic [15:0]        error_q, error_d;
  logic               line_q, line_d;
`ifdef ERR_FILTER_EN
  logic [15:0]        prev_q, prev_d;
  logic signed [16:0] fsum;
`endif

  logic [1:0]         sh;
  logic [16:0]        mag;
  logic signed [16:0] acc_sum;
  logic [15:0]        acc_sat;
  logic               hit;

  function automatic logic [15:0] sat16(input logic signed [16:0] a);
    if (a > 17'sd32767)       return 16'h7FFF;
    else if (a < -17'sd32768) return 16'h8000;
    else                      return a[15:0];
  endfunction

  // Weight magnitude is 2^sh: ch0/ch7 -> 8 .. ch3/ch4 -> 1; lower half subtracts.
  always_comb begin
    sh      = chnnl_q[2] ? chnnl_q[1:0] : ~chnnl_q[1:0];
    mag     = {5'b0, res} << sh;
    acc_sum = chnnl_q[2] ? acc_q + $signed(mag) : acc_q - $signed(mag);
    acc_sat = sat16(acc_sum);
    hit     = res > LINE_THRES;
`ifdef ERR_FILTER_EN
    fsum    = $signed({acc_sat[15], acc_sat}) + $signed({prev_q[15], prev_q});
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      acc_q   <= '0;
      seen_q  <= 1'b0;
      chnnl_q <= '0;
      error_q <= '0;
      line_q  <= 1'b0;
`ifdef ERR_FILTER_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      seen_q  <= seen_d;
      chnnl_q <= chnnl_d;
      error_q <= error_d;
      line_q  <= line_d;
`ifdef ERR_FILTER_EN
      prev_q  <= prev_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    seen_d  = seen_q;
    chnnl_d = chnnl_q;
    error_d = error_q;
    line_d  = line_q;
`ifdef ERR_FILTER_EN
    prev_d  = prev_q;
`endif
    if (!go) begin
      state_d = IDLE;
      timer_d = '0;
      acc_d   = '0;
      seen_d  = 1'b0;
`ifdef ERR_FILTER_EN
      prev_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (timer_q == 16'(PERIOD_CYC - 1)) begin
            state_d = SETTLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        SETTLE: begin
          if (timer_q == 16'(SETTLE_CYC - 1)) begin
            state_d = CONV;
            timer_d = '0;
            chnnl_d = '0;
            acc_d   = '0;
            seen_d  = 1'b0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        CONV: state_d = WAIT;
        WAIT: begin
          if (cnv_cmplt) begin
            acc_d  = acc_sum;
            seen_d = seen_q | hit;
            // Results are loaded on the edge into DONE so they are valid alongside err_vld.
            if (chnnl_q == 3'd7) begin
              state_d = DONE;
              line_d  = seen_q | hit;
`ifdef ERR_FILTER_EN
              error_d = fsum[16:1];
              prev_d  = acc_sat;
`else
              error_d = acc_sat;
`endif
            end else begin
              state_d = CONV;
              chnnl_d = chnnl_q + 3'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          timer_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    strt_cnv = (state_q == CONV);
    IR_en    = (state_q == SETTLE) || (state_q == CONV) || (state_q == WAIT);
    err_vld  = (state_q == DONE);
  end

  assign chnnl        = chnnl_q;
  assign error        = error_q;
  assign line_present = line_q;

endmodule

// File: tb/tb_ir_err_gen.sv
// Bench for ir_err_gen: A2D responder plus frame-level reference model and per-cycle compare.
module tb_ir_err_gen;
  localparam int unsigned P  = 16;
  localparam int unsigned S  = 4;
  localparam logic [11:0] TH = 12'h040;

  logic        clk = 1'b0, rst_n = 1'b0, go = 1'b0, cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        strt_cnv, IR_en, err_vld, line_present;
  logic [2:0]  chnnl;
  logic [15:0] error;

  ir_err_gen #(.PERIOD_CYC(P), .SETTLE_CYC(S), .LINE_THRES(TH)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .cnv_cmplt(cnv_cmplt), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .IR_en(IR_en), .error(error),
    .err_vld(err_vld), .line_present(line_present)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          w [8] = '{-8, -4, -2, -1, 1, 2, 4, 8};
  logic [11:0] frame_res [8];
  int          acc_m = 0, nresp = 0, pend = 0, pch = 0, prev_m = 0;
  int          cyc = 0, last_vld = 0, frames_done = 0;
  bit          seen_m = 0, p_live = 0, gap_ok = 0;
  logic [15:0] exp_err = '0;
  bit          exp_line = 0, exp_vld = 0;

  function automatic int sat16(input int a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // A2D responder and model: answers 3 cycles after strt_cnv; inputs change 1 time unit after negedge.
  initial begin
    int s;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      cnv_cmplt = 1'b0;
      exp_vld   = 1'b0;
      res       = 12'($urandom);
      if (!rst_n) begin
        pend = 0; p_live = 0; nresp = 0; prev_m = 0;
        exp_err = '0; exp_line = 0; gap_ok = 0;
        continue;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cnv_cmplt = 1'b1;
          res       = frame_res[pch];
          if (go && p_live) begin
            acc_m  += w[pch] * int'(res);
            seen_m |= (res > TH);
            nresp++;
            if (nresp == 8) begin
              s = sat16(acc_m);
`ifdef ERR_FILTER_EN
              exp_err = 16'((s + prev_m) >>> 1);
              prev_m  = s;
`else
              exp_err = 16'(s);
`endif
              exp_line = seen_m;
              exp_vld  = 1;
              last_vld = cyc + 1;
              gap_ok   = 1;
            end
          end
        end
      end
      if (strt_cnv) begin
        if (chnnl == 3'd0) begin
          if (gap_ok) chk("frame_gap", 32'(cyc - last_vld), 32'(1 + P + S));
          acc_m = 0; seen_m = 0; nresp = 0;
        end
        chk("strt_chnnl", 32'(chnnl), 32'(nresp));
        gap_ok = 0;
        pend   = 3;
        pch    = int'(chnnl);
        p_live = go;
      end
      if (!go) begin
        p_live = 0; nresp = 0; prev_m = 0; gap_ok = 0;
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("err_vld", 32'(err_vld), 32'(exp_vld));
        chk("error", 32'(error), 32'(exp_err));
        chk("line_present", 32'(line_present), 32'(exp_line));
        if (exp_vld) begin
          chk("IR_en_done", 32'(IR_en), 32'(0));
          frames_done++;
        end
        if (pend > 0 && p_live && go) chk("IR_en_conv", 32'(IR_en), 32'(1));
      end
    end
  end

  task automatic set_all(input logic [11:0] v);
    for (int i = 0; i < 8; i++) frame_res[i] = v;
  endtask

  task automatic wait_frame(input string name);
    int n0 = frames_done;
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (frames_done != n0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no err_vld within 400 cycles", name);
    end
  endtask

  task automatic wait_strt(input logic [2:0] ch);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #2;
      if (strt_cnv && chnnl == ch) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_strt: no strt_cnv on ch%0d within 400 cycles", ch);
    end
  endtask

  task automatic pin(input string name, input logic [15:0] e, input bit l);
    chk(name, 32'(error), 32'(e));
    chk({name, "_line"}, 32'(line_present), 32'(l));
  endtask

  initial begin
    set_all(12'h000);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_strt_cnv", 32'(strt_cnv), 32'(0));
    chk("rst_chnnl", 32'(chnnl), 32'(0));
    chk("rst_IR_en", 32'(IR_en), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    chk("rst_err_vld", 32'(err_vld), 32'(0));
    chk("rst_line", 32'(line_present), 32'(0));
    rst_n = 1'b1;

    // Frame timing, all channels equal
    set_all(12'h100);
    go = 1'b1;
    wait_frame("flat");
`ifndef ERR_FILTER_EN
    pin("flat", 16'h0000, 1);
`endif
    set_all(12'h000); frame_res[7] = 12'hFFF;
    wait_frame("ch7_max");
`ifndef ERR_FILTER_EN
    pin("ch7_max", 16'h7FF8, 1);
`endif
    set_all(12'h000); frame_res[3] = 12'h010;
    wait_frame("ch3_small");
`ifndef ERR_FILTER_EN
    pin("ch3_small", 16'hFFF0, 0);
`endif
    set_all(12'h000); frame_res[6] = 12'hFFF; frame_res[7] = 12'hFFF;
    wait_frame("sat_pos");
`ifndef ERR_FILTER_EN
    pin("sat_pos", 16'h7FFF, 1);
`endif
    set_all(12'h000); frame_res[0] = 12'hFFF; frame_res[1] = 12'hFFF;
    wait_frame("sat_neg");
`ifndef ERR_FILTER_EN
    pin("sat_neg", 16'h8000, 1);
`endif
    set_all(TH);
    wait_frame("at_thres");
`ifndef ERR_FILTER_EN
    pin("at_thres", 16'h0000, 0);
`endif
    set_all(12'h000); frame_res[5] = 12'h041;
    wait_frame("above_thres");
`ifndef ERR_FILTER_EN
    pin("above_thres", 16'h0082, 1);
`endif

    // Abort while waiting on ch3; the late response lands in IDLE
    for (int i = 0; i < 8; i++) frame_res[i] = 12'($urandom);
    wait_strt(3'd3);
    @(negedge clk);
    #2 go = 1'b0;
    @(negedge clk);
    #2;
    chk("abort_IR_en", 32'(IR_en), 32'(0));
`ifndef ERR_FILTER_EN
    pin("abort_hold", 16'h0082, 1);
`endif
    repeat (8) @(negedge clk);
    #2;
    set_all(12'h000); frame_res[4] = 12'd1000;
    go = 1'b1;
    wait_frame("filt1");
`ifdef ERR_FILTER_EN
    pin("filt1", 16'd500, 1);
`else
    pin("filt1", 16'd1000, 1);
`endif
    set_all(12'h000); frame_res[4] = 12'd3000;
    wait_frame("filt2");
`ifdef ERR_FILTER_EN
    pin("filt2", 16'd2000, 1);
`else
    pin("filt2", 16'd3000, 1);
`endif

    // Randomized frames, checked by the model
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 8; i++)
        frame_res[i] = (f % 2 == 1) ? 12'($urandom_range(0, 200)) : 12'($urandom);
      wait_frame("random");
    end

    // Asynchronous reset mid-frame
    wait_strt(3'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strt_cnv", 32'(strt_cnv), 32'(0));
    chk("arst_chnnl", 32'(chnnl), 32'(0));
    chk("arst_IR_en", 32'(IR_en), 32'(0));
    chk("arst_error", 32'(error), 32'(0));
    chk("arst_err_vld", 32'(err_vld), 32'(0));
    chk("arst_line", 32'(line_present), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
